md5_msg_padder: RTL and testbench
=================================

Name: md5_msg_padder

Overview:
- Producer-side front end of the MD5 datapath. It supplies the 16 message words per 512-bit block that the round logic and adders consume.
- Accepts an arbitrary-length little-endian byte message as a 32-bit word stream and emits fully padded MD5 blocks. Padding is the 0x80 marker, zero fill, and the 64-bit bit length in words 14/15.
- Valid/ready on both sides. One registered output stage.

Parameters:
- STATE_DWIDTH, 32, word width (fixed at 32 for MD5; other values unsupported).
- LEN_WIDTH, 64, message bit-length counter width.

Ports:
- Clk  input  1  clock; all state on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- InValid  input  1  input word valid.
- InReady  output  1  padder accepts InData this cycle.
- InData  input  32  message word; byte k of the word in bits [8k+7:8k].
- InLast  input  1  final word of the message.
- InBytes  input  3  valid bytes in the InLast word: 0..4 (0 = empty final word). Ignored when InLast=0. Values 5..7 are treated as 4.
- OutValid  output  1  OutData valid.
- OutReady  input  1  downstream accepts OutData.
- OutData  output  32  padded message word.
- OutWordIdx  output  4  word index within the block, 0..15.
- OutMsgLast  output  1  high on word 15 of the final block of a message.

Behaviour:
- Reset (async, Reset_n=0): OutValid=0, OutData=0, OutWordIdx=0, OutMsgLast=0, InReady=0, state=DATA, idx=0, len=0. This applies mid-message too; any partial message is discarded with no flush.
- Output register advances ("adv") when !OutValid || OutReady. OutData, OutWordIdx and OutMsgLast are held stable while OutValid && !OutReady.
- InReady = (state==DATA) && adv && Reset_n-released. Accept = InValid && InReady.
- Latency: accepted word appears on OutData the next cycle.
- idx is the 4-bit index of the next output word. It increments on every word loaded into the output register and wraps 15->0.
- len accumulates the message bit length: +32 per accepted non-last word, +8*InBytes on the last word. It wraps mod 2^LEN_WIDTH.
- States:
  - DATA:
    - Accepted non-last word passes through unchanged.
    - Accepted last word with n=InBytes<4 emits (InData & mask(n bytes)) | (0x80 << 8n). n=0 therefore emits 0x00000080.
    - Accepted last word with n=4 emits InData unchanged, then goes to PAD80.
    - After emitting the 0x80 byte: if the new idx==14, go to LENLO; otherwise go to ZERO.
  - PAD80: when adv, emit 0x00000080. Next state: LENLO if the new idx==14, else ZERO.
  - ZERO: when adv, emit 0x00000000. Stay in ZERO until the new idx==14, then go to LENLO. This wraps through idx 15->0, which produces the extra block when the pad lands in word 14 or 15.
  - LENLO: when adv, emit len[31:0] at idx 14, then go to LENHI.
  - LENHI: when adv, emit len[63:32] at idx 15 with OutMsgLast=1. Then clear len, return to DATA; idx wraps to 0.
- Input is stalled (InReady=0) in every state except DATA. No new message word is accepted until LENHI has been loaded.
- An extra block is required exactly when the 0x80 byte lands in word 14 or 15. OutMsgLast is never asserted on the first block in that case.
- Back-to-back messages: the first word of the next message may be accepted in the cycle after LENHI is loaded.

Test Plan:
- Empty message: single InLast word, InBytes=0 -> 16 words: 0x00000080, 13x 0x0, 0x00000000, 0x00000000. OutMsgLast only on idx 15.
- "abc": InData=0x00636261, InLast, InBytes=3 -> word0=0x80636261, words1-13=0, word14=0x00000018, word15=0. Single block.
- 55 bytes: 13 full words, then last word at idx 13 with InBytes=3 and data 0x00CCBBAA -> word13=0x80CCBBAA, word14=0x000001B8, word15=0. Single block, OutMsgLast on word 15.
- 56 bytes: 14 full words, last at idx 13 with InBytes=4 -> block1 word14=0x00000080, word15=0, OutMsgLast=0. Block2 words0-13=0, word14=0x000001C0, word15=0, OutMsgLast=1.
- 64 bytes: 16 full words, last at idx 15 with InBytes=4 -> block2 word0=0x00000080, words1-13=0, word14=0x00000200, OutMsgLast on block2 word15. Total output is 32 words.
- Backpressure and reset: random OutReady duty ~30% on the "abc" and 64-byte cases -> identical word sequence, OutData stable while stalled, InReady=0 whenever OutValid && !OutReady. Drop Reset_n mid-ZERO -> OutValid=0 immediately; the next message restarts at idx 0 with len 0.

Source files
------------

// File: rtl/md5_msg_padder.sv
// MD5 message padder: turns a little-endian 32-bit word stream into padded
// 512-bit blocks (0x80 marker, zero fill, 64-bit bit length in words 14/15).
module md5_msg_padder #(
  parameter int STATE_DWIDTH = 32,
  parameter int LEN_WIDTH    = 64
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [STATE_DWIDTH-1:0] InData,
  input  logic                    InLast,
  input  logic [2:0]              InBytes,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [STATE_DWIDTH-1:0] OutData,
  output logic [3:0]              OutWordIdx,
  output logic                    OutMsgLast
);

  typedef enum logic [2:0] {S_DATA, S_PAD80, S_ZERO, S_LENLO, S_LENHI} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic                    out_valid_q, out_valid_d;
  logic [STATE_DWIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]              out_idx_q, out_idx_d;
  logic                    out_last_q, out_last_d;

  logic                    adv, accept, load, last_word;
  logic [2:0]              n_bytes;
  logic [3:0]              idx_inc;
  logic [STATE_DWIDTH-1:0] mask, word;

  always_comb begin
    adv       = !out_valid_q || OutReady;
    InReady   = (state_q == S_DATA) && adv && Reset_n;
    accept    = InValid && InReady;
    n_bytes   = (InBytes > 3'd4) ? 3'd4 : InBytes;
    idx_inc   = idx_q + 4'd1;
    case (n_bytes)
      3'd1:    mask = 32'h0000_00FF;
      3'd2:    mask = 32'h0000_FFFF;
      3'd3:    mask = 32'h00FF_FFFF;
      default: mask = 32'h0000_0000;
    endcase

    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    out_valid_d = adv ? 1'b0 : out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = adv ? 1'b0 : out_last_q;
    load        = 1'b0;
    word        = '0;
    last_word   = 1'b0;

    case (state_q)
      S_DATA: if (accept) begin
        load = 1'b1;
        if (!InLast) begin
          word  = InData;
          len_d = len_q + LEN_WIDTH'(32);
        end else if (n_bytes == 3'd4) begin
          word    = InData;
          len_d   = len_q + LEN_WIDTH'(32);
          state_d = S_PAD80;
        end else begin
          // Marker byte sits right after the last valid byte of this word.
          word    = (InData & mask) | (32'h80 << {n_bytes[1:0], 3'b000});
          len_d   = len_q + LEN_WIDTH'({n_bytes, 3'b000});
          state_d = (idx_inc == 4'd14) ? S_LENLO : S_ZERO;
        end
      end
      S_PAD80: if (adv) begin
        load    = 1'b1;
        word    = 32'h0000_0080;
        state_d = (idx_inc == 4'd14) ? S_LENLO : S_ZERO;
      end
      S_ZERO: if (adv) begin
        load = 1'b1;
        if (idx_inc == 4'd14) state_d = S_LENLO;
      end
      S_LENLO: if (adv) begin
        load    = 1'b1;
        word    = len_q[STATE_DWIDTH-1:0];
        state_d = S_LENHI;
      end
      S_LENHI: if (adv) begin
        load      = 1'b1;
        word      = len_q[2*STATE_DWIDTH-1:STATE_DWIDTH];
        last_word = 1'b1;
        len_d     = '0;
        state_d   = S_DATA;
      end
      default: state_d = S_DATA;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_idx_d   = idx_q;
      out_last_d  = last_word;
      idx_d       = idx_inc;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_DATA;
      idx_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign OutValid   = out_valid_q;
  assign OutData    = out_data_q;
  assign OutWordIdx = out_idx_q;
  assign OutMsgLast = out_last_q;

endmodule

// File: tb/tb_md5_msg_padder.sv
// Bench for md5_msg_padder: byte-level MD5 padding model feeding a scoreboard,
// directed messages from the test plan, backpressure and mid-message reset.
module tb_md5_msg_padder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] InData = '0;
  logic        InLast = 1'b0;
  logic [2:0]  InBytes = '0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] OutData;
  logic [3:0]  OutWordIdx;
  logic        OutMsgLast;

  md5_msg_padder #(.STATE_DWIDTH(32), .LEN_WIDTH(64)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .InLast(InLast), .InBytes(InBytes),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutWordIdx(OutWordIdx), .OutMsgLast(OutMsgLast)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mw[0:63];
  int          mn;
  logic [7:0]  msg[0:255];
  int          checks = 0;
  int          failures = 0;
  bit          bp_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Reference: pad the byte string the MD5 way, then slice into LE words.
  task automatic model_push(input int nb);
    logic [7:0] pb[$];
    longint unsigned bits;
    exp_t e;
    bits = longint'(nb) * 8;
    for (int i = 0; i < nb; i++) pb.push_back(msg[i]);
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    for (int k = 0; k < 8; k++) pb.push_back(8'(bits >> (8 * k)));
    mn = pb.size() / 4;
    for (int w = 0; w < mn; w++) begin
      e.data = {pb[4*w+3], pb[4*w+2], pb[4*w+1], pb[4*w]};
      e.idx  = 4'(w % 16);
      e.last = (w == mn - 1);
      mw[w]  = e;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int nb, input logic [2:0] full_code);
    int nw, t, rem;
    nw = (nb == 0) ? 1 : (nb + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      @(negedge Clk);
      rem = nb - 4 * w;
      for (int b = 0; b < 4; b++)
        InData[8*b +: 8] = (b < rem) ? msg[4*w+b] : 8'hEE;
      InValid = 1'b1;
      InLast  = (w == nw - 1);
      InBytes = (w != nw - 1) ? 3'd0 : (rem >= 4) ? full_code : 3'(rem);
      #2;
      t = 0;
      while (!InReady && t < 1000) begin
        @(negedge Clk); #2; t++;
      end
      if (t >= 1000) chk("in_accept_timeout", 64'(t), 64'd0);
    end
    @(negedge Clk);
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic drain;
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge Clk); t++;
    end
    if (t >= 3000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge Clk);
  endtask

  task automatic fill_pattern(input int nb);
    for (int i = 0; i < nb; i++) msg[i] = 8'(i + 1);
  endtask

  always @(negedge Clk) OutReady <= bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;

  // Scoreboard, plus hold/stall rules, sampled mid-low-phase.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;
  logic        prev_last;
  initial forever begin
    @(negedge Clk); #3;
    if (!Reset_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(OutValid), 64'd1);
        chk("hold_data", 64'({OutData, OutWordIdx, OutMsgLast}),
            64'({prev_data, prev_idx, prev_last}));
      end
      if (OutValid && !OutReady) chk("stall_inready", 64'(InReady), 64'd0);
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) chk("unexpected_word", 64'(OutData), 64'hDEAD);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(OutData), 64'(e.data));
          chk("out_idx", 64'(OutWordIdx), 64'(e.idx));
          chk("out_last", 64'(OutMsgLast), 64'(e.last));
        end
      end
      prev_stall = OutValid && !OutReady;
      prev_data  = OutData;
      prev_idx   = OutWordIdx;
      prev_last  = OutMsgLast;
    end
  end

  initial begin
    int t;
    #1;
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_outdata", 64'(OutData), 64'd0);
    chk("rst_idx", 64'(OutWordIdx), 64'd0);
    chk("rst_last", 64'(OutMsgLast), 64'd0);
    chk("rst_inready", 64'(InReady), 64'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Empty message
    model_push(0);
    chk("m_empty_n", 64'(mn), 64'd16);
    chk("m_empty_w0", 64'(mw[0].data), 64'h80);
    chk("m_empty_w14", 64'(mw[14].data), 64'h0);
    send(0, 3'd4);
    drain();

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    model_push(3);
    chk("m_abc_w0", 64'(mw[0].data), 64'h80636261);
    chk("m_abc_w14", 64'(mw[14].data), 64'h18);
    send(3, 3'd4);
    drain();

    // 55 bytes then 56 bytes back to back
    fill_pattern(55);
    msg[52] = 8'hAA; msg[53] = 8'hBB; msg[54] = 8'hCC;
    model_push(55);
    chk("m_55_w13", 64'(mw[13].data), 64'h80CCBBAA);
    chk("m_55_w14", 64'(mw[14].data), 64'h1B8);
    send(55, 3'd4);
    fill_pattern(56);
    model_push(56);
    chk("m_56_n", 64'(mn), 64'd32);
    chk("m_56_w14", 64'(mw[14].data), 64'h80);
    chk("m_56_w15last", 64'(mw[15].last), 64'd0);
    chk("m_56_w30", 64'(mw[30].data), 64'h1C0);
    send(56, 3'd4);
    drain();

    // 64 bytes
    fill_pattern(64);
    model_push(64);
    chk("m_64_w16", 64'(mw[16].data), 64'h80);
    chk("m_64_w30", 64'(mw[30].data), 64'h200);
    send(64, 3'd4);
    drain();

    // 8 bytes with an out-of-range full-word count on the last word
    fill_pattern(8);
    model_push(8);
    send(8, 3'd7);
    drain();

    // Backpressure on "abc" and 64 bytes
    bp_mode = 1'b1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    model_push(3);
    send(3, 3'd4);
    drain();
    fill_pattern(64);
    model_push(64);
    send(64, 3'd4);
    drain();
    bp_mode = 1'b0;

    // Reset in the middle of the zero fill
    model_push(0);
    send(0, 3'd4);
    t = 0;
    while (!(OutValid && OutWordIdx == 4'd5) && t < 200) begin
      @(negedge Clk); #1; t++;
    end
    if (t >= 200) chk("zero_wait_timeout", 64'(t), 64'd0);
    @(negedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    chk("midrst_outvalid", 64'(OutValid), 64'd0);
    chk("midrst_inready", 64'(InReady), 64'd0);
    chk("midrst_idx", 64'(OutWordIdx), 64'd0);
    exp_q.delete();
    @(negedge Clk); #1;
    Reset_n = 1'b1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    model_push(3);
    send(3, 3'd4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
